// File: rtl/phase_arbiter_pkg.sv
// Shared phase and FSM encodings for the phase arbiter and the traffic light controller.
// Also holds the grant priority function so every user picks phases the same way.
package phase_arbiter_pkg;

    typedef enum logic [1:0] {
        PH_NONE = 2'b00,
        PH_NS   = 2'b01,
        PH_EW   = 2'b10,
        PH_PED  = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EVAL  = 2'b01,
        ST_GRANT = 2'b10
    } state_t;

    // pend is {ped, ew, ns}; age_hit is already qualified by a pending ped request.
    function automatic phase_t pick_phase(input logic [2:0] pend,
                                          input phase_t     last_car,
                                          input logic       age_hit);
        if (age_hit)
            return PH_PED;
        if (pend[2] && !pend[1] && !pend[0])
            return PH_PED;
        if (pend[1] ^ pend[0])
            return pend[0] ? PH_NS : PH_EW;
        return (last_car == PH_NS) ? PH_EW : PH_NS;
    endfunction

endpackage

// File: rtl/phase_arbiter_if.sv
// Request/grant bundle between the light controller (master) and the phase arbiter (slave).
interface phase_arbiter_if;
    logic       car_ns;
    logic       car_ew;
    logic       ped;
    logic       decide;
    logic       grant_ack;
    logic       grant_valid;
    logic [1:0] grant_phase;
    logic [2:0] pend;
    logic       starve_alarm;

    modport slave (
        input  car_ns, car_ew, ped, decide, grant_ack,
        output grant_valid, grant_phase, pend, starve_alarm
    );

    modport master (
        output car_ns, car_ew, ped, decide, grant_ack,
        input  grant_valid, grant_phase, pend, starve_alarm
    );
endinterface

// File: rtl/phase_req_latch.sv
// Sticky request bit: set dominates clear so a request arriving on its own ack is kept.
module phase_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clear,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (clear)
            q <= 1'b0;
    end
endmodule

// File: rtl/phase_arbiter.sv
// Picks the next light phase from latched car/pedestrian requests on each decide.
// Optional pedestrian aging (ped_age, forced PED grant, starve_alarm) under PHASE_ARB_AGING_EN.
//
// state    | meaning
// ST_IDLE  | waiting for decide
// ST_EVAL  | pend snapshot is being used to choose a phase
// ST_GRANT | grant presented, held until grant_ack
module phase_arbiter
    import phase_arbiter_pkg::*;
#(
    parameter logic [3:0] AGE_MAX = 4'd3
) (
    input  logic            clk,
    input  logic            rst,
    phase_arbiter_if.slave  bus
);
    state_t     state_q, state_d;
    logic [2:0] pend;
    logic       grant_valid_q;
    phase_t     grant_phase_q;
    phase_t     last_car_q;
    phase_t     pick;
    logic       ack_fire;
    logic       age_hit;

    if (AGE_MAX == 4'd0) begin : g_age_max_range
        $error("phase_arbiter: AGE_MAX must be in 1..15");
    end

    assign ack_fire = (state_q == ST_GRANT) && bus.grant_ack;

    phase_req_latch u_req_ns (
        .clk(clk), .rst(rst), .set(bus.car_ns),
        .clear(ack_fire && (grant_phase_q == PH_NS)), .q(pend[0])
    );
    phase_req_latch u_req_ew (
        .clk(clk), .rst(rst), .set(bus.car_ew),
        .clear(ack_fire && (grant_phase_q == PH_EW)), .q(pend[1])
    );
    phase_req_latch u_req_ped (
        .clk(clk), .rst(rst), .set(bus.ped),
        .clear(ack_fire && (grant_phase_q == PH_PED)), .q(pend[2])
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.decide) state_d = ST_EVAL;
            ST_EVAL:  state_d = ST_GRANT;
            ST_GRANT: if (bus.grant_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef PHASE_ARB_AGING_EN
    logic [3:0] ped_age_q, ped_age_d;
    logic       starve_q;

    // Age counts decisions the waiting pedestrian lost; any ped grant or idle ped resets it.
    always_comb begin
        ped_age_d = ped_age_q;
        if (ack_fire) begin
            if (!pend[2] || (grant_phase_q == PH_PED))
                ped_age_d = 4'd0;
            else if (ped_age_q < AGE_MAX)
                ped_age_d = ped_age_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_age_q <= 4'd0;
            starve_q  <= 1'b0;
        end else begin
            ped_age_q <= ped_age_d;
            starve_q  <= (ped_age_d == AGE_MAX);
        end
    end

    assign age_hit          = pend[2] && (ped_age_q == AGE_MAX);
    assign bus.starve_alarm = starve_q;
`else
    assign age_hit          = 1'b0;
    assign bus.starve_alarm = 1'b0;
`endif

    assign pick = pick_phase(pend, last_car_q, age_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid_q <= 1'b0;
            grant_phase_q <= PH_NONE;
            last_car_q    <= PH_EW;
        end else if (state_q == ST_EVAL) begin
            grant_valid_q <= 1'b1;
            grant_phase_q <= pick;
        end else if (ack_fire) begin
            grant_valid_q <= 1'b0;
            grant_phase_q <= PH_NONE;
            if ((grant_phase_q == PH_NS) || (grant_phase_q == PH_EW))
                last_car_q <= grant_phase_q;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_phase = grant_phase_q;
    assign bus.pend        = pend;
endmodule

// File: tb/tb_phase_arbiter.sv
// Directed bench for phase_arbiter; expected grants hand-derived from the priority rules.
module tb_phase_arbiter;
`ifdef PHASE_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    phase_arbiter_if bus ();

    phase_arbiter #(.AGE_MAX(4'd2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_decide();
        bus.decide = 1'b1;
        step();
        bus.decide = 1'b0;
        step();
    endtask

    task automatic do_ack();
        bus.grant_ack = 1'b1;
        step();
        bus.grant_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.grant_valid); end
        checks++; if (bus.grant_phase !== 2'b00) begin errors++; $display("FAIL reset_phase: got %b expected 00", bus.grant_phase); end
        checks++; if (bus.pend !== 3'b000) begin errors++; $display("FAIL reset_pend: got %b expected 000", bus.pend); end
        checks++; if (bus.starve_alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", bus.starve_alarm); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_no_requests();
        bus.decide = 1'b1;
        step();
        bus.decide = 1'b0;
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL noreq_eval_valid: got %b expected 0", bus.grant_valid); end
        step();
        checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL noreq_valid: got %b expected 1", bus.grant_valid); end
        checks++; if (bus.grant_phase !== 2'b01) begin errors++; $display("FAIL noreq_first_phase: got %b expected 01", bus.grant_phase); end
        do_ack();
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL noreq_ack_valid: got %b expected 0", bus.grant_valid); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b10) begin errors++; $display("FAIL noreq_second_phase: got %b expected 10", bus.grant_phase); end
        do_ack();
    endtask

    task automatic test_ew_only();
        // last_car is EW after the previous test
        bus.car_ew = 1'b1;
        step();
        bus.car_ew = 1'b0;
        checks++; if (bus.pend !== 3'b010) begin errors++; $display("FAIL ew_pend_set: got %b expected 010", bus.pend); end
        do_ack();
        checks++; if (bus.pend !== 3'b010) begin errors++; $display("FAIL ew_ack_idle_ignored: got %b expected 010", bus.pend); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b10) begin errors++; $display("FAIL ew_only_phase: got %b expected 10", bus.grant_phase); end
        do_ack();
        checks++; if (bus.pend !== 3'b000) begin errors++; $display("FAIL ew_ack_clear: got %b expected 000", bus.pend); end
        bus.car_ew = 1'b1;
        do_decide();
        checks++; if (bus.grant_phase !== 2'b10) begin errors++; $display("FAIL ew_held_phase: got %b expected 10", bus.grant_phase); end
        do_ack();
        checks++; if (bus.pend !== 3'b010) begin errors++; $display("FAIL ew_set_wins: got %b expected 010", bus.pend); end
        bus.car_ew = 1'b0;
        do_reset();
    endtask

    task automatic test_ped_pulse();
        bus.ped = 1'b1;
        step();
        bus.ped = 1'b0;
        checks++; if (bus.pend !== 3'b100) begin errors++; $display("FAIL ped_pend_set: got %b expected 100", bus.pend); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b11) begin errors++; $display("FAIL ped_phase: got %b expected 11", bus.grant_phase); end
        do_ack();
        checks++; if (bus.pend !== 3'b000) begin errors++; $display("FAIL ped_ack_clear: got %b expected 000", bus.pend); end
    endtask

    task automatic test_aging();
        logic [1:0] exp_third;
        logic [1:0] exp_fourth;
        logic       exp_alarm2;
        exp_third  = AGING ? 2'b11 : 2'b01;
        exp_fourth = AGING ? 2'b01 : 2'b10;
        exp_alarm2 = AGING;
        do_reset();
        bus.ped    = 1'b1;
        bus.car_ns = 1'b1;
        bus.car_ew = 1'b1;
        step();
        bus.ped = 1'b0;
        checks++; if (bus.pend !== 3'b111) begin errors++; $display("FAIL age_pend: got %b expected 111", bus.pend); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b01) begin errors++; $display("FAIL age_grant1: got %b expected 01", bus.grant_phase); end
        do_ack();
        checks++; if (bus.starve_alarm !== 1'b0) begin errors++; $display("FAIL age_alarm1: got %b expected 0", bus.starve_alarm); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b10) begin errors++; $display("FAIL age_grant2: got %b expected 10", bus.grant_phase); end
        do_ack();
        checks++; if (bus.starve_alarm !== exp_alarm2) begin errors++; $display("FAIL age_alarm2: got %b expected %b", bus.starve_alarm, exp_alarm2); end
        do_decide();
        checks++; if (bus.grant_phase !== exp_third) begin errors++; $display("FAIL age_grant3: got %b expected %b", bus.grant_phase, exp_third); end
        do_ack();
        checks++; if (bus.starve_alarm !== 1'b0) begin errors++; $display("FAIL age_alarm3: got %b expected 0", bus.starve_alarm); end
        do_decide();
        checks++; if (bus.grant_phase !== exp_fourth) begin errors++; $display("FAIL age_grant4: got %b expected %b", bus.grant_phase, exp_fourth); end
        do_ack();
        bus.car_ns = 1'b0;
        bus.car_ew = 1'b0;
        do_reset();
    endtask

    task automatic test_hold_in_grant();
        bus.car_ns = 1'b1;
        step();
        bus.car_ns = 1'b0;
        do_decide();
        checks++; if (bus.grant_phase !== 2'b01) begin errors++; $display("FAIL hold_initial_phase: got %b expected 01", bus.grant_phase); end
        for (int i = 0; i < 5; i++) begin
            bus.decide = (i == 1);
            bus.ped    = (i == 3);
            step();
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_phase !== 2'b01) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b phase=%b expected valid=1 phase=01", i, bus.grant_valid, bus.grant_phase);
            end
        end
        bus.decide = 1'b0;
        bus.ped    = 1'b0;
        checks++; if (bus.pend !== 3'b101) begin errors++; $display("FAIL hold_pend: got %b expected 101", bus.pend); end
        do_ack();
        checks++; if (bus.pend !== 3'b100) begin errors++; $display("FAIL hold_ack_pend: got %b expected 100", bus.pend); end
        step();
        step();
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL hold_no_new_decision: got %b expected 0", bus.grant_valid); end
        do_reset();
    endtask

    task automatic test_reset_in_grant();
        do_decide();
        do_ack();
        bus.car_ew = 1'b1;
        step();
        bus.car_ew = 1'b0;
        do_decide();
        checks++; if (bus.grant_phase !== 2'b10) begin errors++; $display("FAIL rstg_pre_phase: got %b expected 10", bus.grant_phase); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rstg_valid: got %b expected 0", bus.grant_valid); end
        checks++; if (bus.pend !== 3'b000) begin errors++; $display("FAIL rstg_pend: got %b expected 000", bus.pend); end
        checks++; if (bus.grant_phase !== 2'b00) begin errors++; $display("FAIL rstg_phase: got %b expected 00", bus.grant_phase); end
        do_decide();
        checks++; if (bus.grant_phase !== 2'b01) begin errors++; $display("FAIL rstg_post_phase: got %b expected 01", bus.grant_phase); end
        do_ack();
    endtask

    initial begin
        bus.car_ns    = 1'b0;
        bus.car_ew    = 1'b0;
        bus.ped       = 1'b0;
        bus.decide    = 1'b0;
        bus.grant_ack = 1'b0;
        test_reset();
        test_no_requests();
        test_ew_only();
        test_ped_pulse();
        test_aging();
        test_hold_in_grant();
        test_reset_in_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
